// File: rtl/rcc_bus_clk_en_gen.sv
// rtl/rcc_bus_clk_en_gen.sv - per-channel bus clock-enable generator with ratio handshake and idle gating
module rcc_bus_clk_en_gen #(
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 3,
    parameter int RST_SEL   = 0,
    parameter int IDLE_HOLD = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NUM_CH*SEL_W-1:0] div_sel,
    input  logic [NUM_CH-1:0]       div_req,
    output logic [NUM_CH-1:0]       div_ack,
    output logic [NUM_CH*SEL_W-1:0] div_cur,
    input  logic [NUM_CH-1:0]       sleep_req,
    input  logic [NUM_CH-1:0]       busy,
    input  logic                    sys_stop,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic [NUM_CH-1:0]       ch_on
);

    localparam int CNT_W  = (1 << SEL_W) - 1;
    localparam int HOLD_W = (IDLE_HOLD < 2) ? 1 : $clog2(IDLE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IDLE_HOLD);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HOLD,
        ST_OFF
    } gate_state_t;

    logic [CNT_W-1:0] cnt;

    // True when the low r bits of the shared phase counter are all ones.
    function automatic logic low_ones(input logic [CNT_W-1:0] c, input logic [SEL_W-1:0] r);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < CNT_W; b++) begin
            if (b < int'(r) && !c[b]) ok = 1'b0;
        end
        return ok;
    endfunction

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) cnt <= '0;
        else         cnt <= cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SEL_W-1:0]  req_sel;
        logic [SEL_W-1:0]  cur_sel;
        logic [SEL_W-1:0]  pend_sel;
        logic [SEL_W-1:0]  span_sel;
        logic              pend;
        logic              aligned;
        logic              apply;
        logic              ack_q;
        logic              tick_q;
        logic              en_q;
        logic              wake;
        gate_state_t       state;
        gate_state_t       state_nxt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_nxt;

        assign req_sel  = div_sel[i*SEL_W +: SEL_W];
        assign span_sel = (pend_sel > cur_sel) ? pend_sel : cur_sel;
        assign aligned  = low_ones(cnt, cur_sel);
        // Switching only where both old and new boundaries coincide avoids runt or stretched ticks.
        assign apply    = pend & low_ones(cnt, span_sel);
        assign wake     = ~sleep_req[i] | busy[i];

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                cur_sel  <= SEL_W'(RST_SEL);
                pend_sel <= SEL_W'(RST_SEL);
                pend     <= 1'b0;
                ack_q    <= 1'b0;
                tick_q   <= 1'b0;
                en_q     <= 1'b0;
                state    <= ST_RUN;
                hold_cnt <= '0;
            end else begin
                tick_q   <= aligned;
                en_q     <= aligned & (state != ST_OFF) & ~sys_stop;
                ack_q    <= apply;
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
                if (apply) cur_sel <= pend_sel;
                if (div_req[i]) begin
                    pend     <= 1'b1;
                    pend_sel <= req_sel;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            case (state)
                ST_RUN: begin
                    if (!wake) begin
                        hold_nxt  = '0;
                        state_nxt = (IDLE_HOLD == 0) ? ST_OFF : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (wake) begin
                        state_nxt = ST_RUN;
                    end else if (aligned) begin
                        hold_nxt = hold_cnt + 1'b1;
                        if (hold_cnt + 1'b1 == HOLD_LAST) state_nxt = ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (wake) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end

        assign div_ack[i]                 = ack_q;
        assign div_cur[i*SEL_W +: SEL_W]  = cur_sel;
        assign ch_tick[i]                 = tick_q;
        assign ch_clk_en[i]               = en_q;
        assign ch_on[i]                   = (state != ST_OFF) & ~sys_stop;
    end

endmodule

// File: tb/tb_rcc_bus_clk_en_gen.sv
// tb/tb_rcc_bus_clk_en_gen.sv - directed self-checking bench for rcc_bus_clk_en_gen
module tb_rcc_bus_clk_en_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [11:0] div_sel;
    logic [3:0]  div_req;
    logic [3:0]  div_ack;
    logic [11:0] div_cur;
    logic [3:0]  sleep_req;
    logic [3:0]  busy;
    logic        sys_stop;
    logic [3:0]  ch_tick;
    logic [3:0]  ch_clk_en;
    logic [3:0]  ch_on;

    int checks = 0;
    int errors = 0;
    logic [6:0] m_cnt;
    int model_sel [4];

    rcc_bus_clk_en_gen #(
        .NUM_CH(4), .SEL_W(3), .RST_SEL(0), .IDLE_HOLD(4)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .div_sel(div_sel), .div_req(div_req),
        .div_ack(div_ack), .div_cur(div_cur), .sleep_req(sleep_req), .busy(busy),
        .sys_stop(sys_stop), .ch_tick(ch_tick), .ch_clk_en(ch_clk_en), .ch_on(ch_on)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) m_cnt <= '0;
        else         m_cnt <= m_cnt + 7'd1;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_phase(input logic [6:0] mask, input logic [6:0] val);
        int n = 0;
        while ((m_cnt & mask) != val && n < 200) begin
            step();
            n++;
        end
    endtask

    function automatic logic [3:0] exp_tick(input logic [6:0] c);
        logic [3:0] t;
        int p;
        int m;
        p = (int'(c) + 127) % 128;
        for (int i = 0; i < 4; i++) begin
            m = (1 << model_sel[i]) - 1;
            t[i] = ((p & m) == m);
        end
        return t;
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1;
        sys_stop = 1'b1;
        #1;
        checks++;
        if (ch_on !== 4'h0) begin errors++; $display("FAIL rst_on_stop got %h want 0", ch_on); end
        sys_stop = 1'b0;
        #1;
        checks++;
        if (ch_on !== 4'hF) begin errors++; $display("FAIL rst_on got %h want f", ch_on); end
        checks++;
        if ({ch_tick, ch_clk_en, div_ack} !== 12'h0) begin
            errors++; $display("FAIL rst_outs got %h want 0", {ch_tick, ch_clk_en, div_ack});
        end
        checks++;
        if (div_cur !== 12'h0) begin errors++; $display("FAIL rst_div_cur got %h want 0", div_cur); end
        step();
        step();
        sys_rst = 1'b0;
        checks++;
        if (ch_clk_en !== 4'h0) begin errors++; $display("FAIL rel_cycle0 got %h want 0", ch_clk_en); end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (ch_clk_en !== 4'hF || ch_tick !== 4'hF) begin
                errors++; $display("FAIL rel_en cycle %0d got %h/%h want f/f", k, ch_clk_en, ch_tick);
            end
        end
    endtask

    task automatic test_ratio_change();
        int last = -1;
        int gap_max = 0;
        logic exp_en;
        wait_phase(7'h7F, 7'd5);
        div_sel[2:0] = 3'd2;
        div_req[0] = 1'b1;
        step();
        div_req[0] = 1'b0;
        while (m_cnt != 7'd30) begin
            exp_en = (m_cnt <= 7'd8) || (m_cnt[1:0] == 2'b00);
            checks++;
            if (ch_clk_en[0] !== exp_en) begin
                errors++; $display("FAIL ratio_en cnt %0d got %b want %b", m_cnt, ch_clk_en[0], exp_en);
            end
            checks++;
            if (div_ack[0] !== (m_cnt == 7'd8)) begin
                errors++; $display("FAIL ratio_ack cnt %0d got %b want %b", m_cnt, div_ack[0], m_cnt == 7'd8);
            end
            checks++;
            if (div_cur[2:0] !== ((m_cnt >= 7'd8) ? 3'd2 : 3'd0)) begin
                errors++; $display("FAIL ratio_cur cnt %0d got %0d", m_cnt, div_cur[2:0]);
            end
            if (ch_clk_en[0] === 1'b1) begin
                if (last >= 0 && int'(m_cnt) - last > gap_max) gap_max = int'(m_cnt) - last;
                last = int'(m_cnt);
            end
            step();
        end
        checks++;
        if (gap_max != 4) begin errors++; $display("FAIL ratio_gap got %0d want 4", gap_max); end
        model_sel[0] = 2;
    endtask

    task automatic test_overwrite();
        int n = 0;
        div_sel[5:3] = 3'd3;
        div_req[1] = 1'b1;
        step();
        div_req[1] = 1'b0;
        while (div_ack[1] !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (div_ack[1] !== 1'b1 || m_cnt[2:0] != 3'd0) begin
            errors++; $display("FAIL ow_setup_ack got %b at phase %0d want 1 at 0", div_ack[1], m_cnt[2:0]);
        end
        wait_phase(7'h07, 7'd1);
        div_sel[5:3] = 3'd1;
        div_req[1] = 1'b1;
        step();
        div_sel[5:3] = 3'd0;
        step();
        div_req[1] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (div_ack[1] !== (k == 5)) begin
                errors++; $display("FAIL ow_ack step %0d got %b want %b", k, div_ack[1], k == 5);
            end
            checks++;
            if (ch_tick[1] !== (k >= 5)) begin
                errors++; $display("FAIL ow_tick step %0d got %b want %b", k, ch_tick[1], k >= 5);
            end
            checks++;
            if (div_cur[5:3] !== ((k < 5) ? 3'd3 : 3'd0)) begin
                errors++; $display("FAIL ow_cur step %0d got %0d", k, div_cur[5:3]);
            end
            step();
        end
        model_sel[1] = 0;
    endtask

    task automatic test_back_to_back();
        div_sel[11:9] = 3'd0;
        div_req[3] = 1'b1;
        step();
        checks++;
        if (div_ack[3] !== 1'b0) begin errors++; $display("FAIL b2b_ack0 got %b want 0", div_ack[3]); end
        step();
        div_req[3] = 1'b0;
        checks++;
        if (div_ack[3] !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b want 1", div_ack[3]); end
        step();
        checks++;
        if (div_ack[3] !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b want 1", div_ack[3]); end
        step();
        checks++;
        if (div_ack[3] !== 1'b0) begin errors++; $display("FAIL b2b_ack3 got %b want 0", div_ack[3]); end
    endtask

    task automatic test_sleep_hold();
        int n = 0;
        int pulses = 0;
        div_sel[8:6] = 3'd1;
        div_req[2] = 1'b1;
        step();
        div_req[2] = 1'b0;
        while (div_ack[2] !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (div_cur[8:6] !== 3'd1) begin errors++; $display("FAIL sh_setup_cur got %0d want 1", div_cur[8:6]); end
        model_sel[2] = 1;
        wait_phase(7'h01, 7'd0);
        sleep_req[2] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            checks++;
            if (ch_clk_en[2] !== (k <= 8 && k % 2 == 0)) begin
                errors++; $display("FAIL sh_en step %0d got %b want %b", k, ch_clk_en[2], k <= 8 && k % 2 == 0);
            end
            checks++;
            if (ch_on[2] !== (k <= 7)) begin
                errors++; $display("FAIL sh_on step %0d got %b want %b", k, ch_on[2], k <= 7);
            end
            if (ch_clk_en[2] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 4) begin errors++; $display("FAIL sh_pulses got %0d want 4", pulses); end
        busy[2] = 1'b1;
        step();
        busy[2] = 1'b0;
        checks++;
        if (ch_on[2] !== 1'b1 || ch_clk_en[2] !== 1'b0) begin
            errors++; $display("FAIL sh_wake got on=%b en=%b want on=1 en=0", ch_on[2], ch_clk_en[2]);
        end
        step();
        checks++;
        if (ch_clk_en[2] !== 1'b1) begin errors++; $display("FAIL sh_wake_en got %b want 1", ch_clk_en[2]); end
        sleep_req[2] = 1'b0;
        step();
        step();
    endtask

    task automatic test_hold_abort();
        wait_phase(7'h01, 7'd0);
        sleep_req[2] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (ch_on[2] !== (k < 14)) begin
                errors++; $display("FAIL ha_on step %0d got %b want %b", k, ch_on[2], k < 14);
            end
            if (k == 4) busy[2] = 1'b1;
            if (k == 5) busy[2] = 1'b0;
        end
        sleep_req[2] = 1'b0;
        step();
        step();
    endtask

    task automatic test_sys_stop();
        sys_stop = 1'b1;
        #1;
        checks++;
        if (ch_on !== 4'h0) begin errors++; $display("FAIL stop_on got %h want 0", ch_on); end
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (ch_clk_en !== 4'h0) begin errors++; $display("FAIL stop_en step %0d got %h want 0", k, ch_clk_en); end
            checks++;
            if (ch_tick !== exp_tick(m_cnt)) begin
                errors++; $display("FAIL stop_tick step %0d got %h want %h", k, ch_tick, exp_tick(m_cnt));
            end
        end
        sys_stop = 1'b0;
        #1;
        checks++;
        if (ch_on !== 4'hF) begin errors++; $display("FAIL stop_rel_on got %h want f", ch_on); end
        for (int k = 11; k <= 22; k++) begin
            step();
            checks++;
            if (ch_clk_en !== exp_tick(m_cnt)) begin
                errors++; $display("FAIL stop_resume step %0d got %h want %h", k, ch_clk_en, exp_tick(m_cnt));
            end
        end
    endtask

    initial begin
        sys_rst = 1'b0;
        div_sel = '0;
        div_req = '0;
        sleep_req = '0;
        busy = '0;
        sys_stop = 1'b0;
        for (int i = 0; i < 4; i++) model_sel[i] = 0;
        #2;
        test_reset();
        test_ratio_change();
        test_overwrite();
        test_back_to_back();
        test_sleep_hold();
        test_hold_abort();
        test_sys_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rcc_bus_clk_en_gen.md
Name: rcc_bus_clk_en_gen

Overview:
- Parametrised successor to the bus prescaler/gating chain in the RCC system clock generator.
- Instead of producing divided, gated clocks per bus bridge, it runs entirely on sys_clk and produces per-channel single-cycle clock-enable pulses.
- Each channel has a runtime divide ratio of 2^sel. Ratio changes are handshaked and applied only at phase-aligned boundaries.
- Each channel has a sleep/busy auto-gating state machine with a programmable idle hold-off.

Parameters:
- NUM_CH, 4, number of independent bus channels.
- SEL_W, 3, width of each ratio selector. Max divide is 2^(2^SEL_W-1), i.e. 128 at default. Prescaler counter width CNT_W = 2^SEL_W-1.
- RST_SEL, 0, ratio selector loaded into every channel at reset.
- IDLE_HOLD, 4, number of channel ticks spent in HOLD before gating OFF. 0 means gate immediately.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- div_sel  in  NUM_CH*SEL_W  requested ratio per channel; slice i is [i*SEL_W +: SEL_W].
- div_req  in  NUM_CH  one-cycle pulse; captures div_sel slice i as the pending ratio.
- div_ack  out  NUM_CH  one-cycle pulse; the new ratio is now in effect.
- div_cur  out  NUM_CH*SEL_W  ratio currently in effect.
- sleep_req  in  NUM_CH  requester asleep (CPU sleep or domain idle).
- busy  in  NUM_CH  bridge or peripheral busy; overrides sleep.
- sys_stop  in  1  global stop; suppresses all enables.
- ch_tick  out  NUM_CH  registered ungated tick at the current ratio.
- ch_clk_en  out  NUM_CH  registered, gated clock-enable pulse.
- ch_on  out  NUM_CH  channel gate open: state != OFF and ~sys_stop.

Behaviour:

Reset (async, sys_rst=1):
- cnt=0; every div_cur=RST_SEL; no pending request.
- All FSMs in RUN; hold counters 0.
- ch_tick, ch_clk_en, div_ack all 0; ch_on = ~sys_stop.

Prescaler:
- Single shared free-running CNT_W-bit counter, +1 every cycle, wraps 2^CNT_W-1 -> 0.
- All channels share this phase.

Tick:
- aligned_i(t) = (cnt low r bits all ones), where r = div_cur_i. r=0 is always true.
- ch_tick_i is registered: high in cycle t+1 iff aligned_i(t).
- With RST_SEL=r, the first pulse comes 2^r cycles after reset release, then every 2^r cycles. r=0 gives continuous high.
- ch_clk_en_i = registered (aligned_i & state_i != OFF & ~sys_stop).

Ratio change:
- div_req_i sets pending_i and stores the new selector n.
- A new div_req while pending overwrites n; only one ack is produced.
- Apply edge: first edge where cnt low max(old,n) bits are all ones.
  - On that edge: div_cur_i <= n, pending cleared, div_ack_i high the next cycle.
  - The tick for that cycle uses the old ratio; the old boundary coincides, so there is no short or long pulse.
- div_req with n == old acks at the next old boundary.
- div_req in the same cycle as the apply edge is treated as an overwrite arriving after the apply: it starts a new pending request.
- Ratio changes proceed during sys_stop and in any FSM state.

Gating FSM per channel (states RUN, HOLD, OFF):
- RUN -> HOLD when sleep_req & ~busy; the hold counter is cleared.
- HOLD:
  - Back to RUN when ~sleep_req | busy.
  - Otherwise the counter increments on each aligned_i.
  - -> OFF when the counter reaches IDLE_HOLD; with IDLE_HOLD=0, RUN goes straight to OFF.
  - Enables keep being delivered while in HOLD.
- OFF -> RUN when ~sleep_req | busy. Enables resume at the next natural tick boundary, with no phase reset.
- sys_stop does not change FSM state. It only masks ch_clk_en and ch_on, effective from the next cycle for ch_clk_en and immediately for ch_on.
- Reset mid-operation: everything returns to reset values asynchronously and pending requests are discarded.

Test Plan:
- Reset release, RST_SEL=0, NUM_CH=4 -> ch_clk_en all 1 every cycle from cycle 1; div_cur=0; div_ack=0.
- Ch0 div_sel=2, req at cnt=5 -> apply at the edge where cnt=7, div_ack high at cnt=8; then ch_clk_en0 pulses every 4 cycles, first at cnt=12; no pulse gap greater than 4 across the switch.
- Ch1 at sel=3, req 1 then req 0 before the boundary -> single ack at the next cnt low 3 bits = 111; final div_cur1=0.
- Ch2 sel=1, IDLE_HOLD=4, sleep_req=1, busy=0 -> 4 more enable pulses during HOLD, then OFF (ch_on2=0, ch_clk_en2=0); busy pulse -> RUN and enable at the next odd-cnt boundary.
- HOLD with busy asserted after 2 ticks -> returns to RUN; a later sleep restarts a full 4-tick hold.
- sys_stop=1 for 10 cycles with all channels in RUN -> ch_clk_en all 0, ch_on all 0, ch_tick continues, states unchanged; after deassert, pulses resume at the original phase.
